// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU button controller slice.
//   OPERAND_W     : width of the switch operands
//   OP_ADD/OP_SUB : encoding of the op_sel output
//   state_t       : request FSM states
//   operand_t     : operand word type
package alu_ctrl_pkg;

  localparam int unsigned OPERAND_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RELEASE
  } state_t;

  typedef logic [OPERAND_W-1:0] operand_t;

endpackage

// File: rtl/alu_btn_ctrl_if.sv
// Operation request channel from the button controller to the ALU.
//   op_valid : request pending (master -> slave)
//   op_ready : slave accepts the request this cycle (slave -> master)
//   op_sel   : 0 = add, 1 = subtract
//   op_a     : latched operand A
//   op_b     : latched operand B
interface alu_btn_ctrl_if
  import alu_ctrl_pkg::*;
  ();

  logic     op_valid;
  logic     op_ready;
  logic     op_sel;
  operand_t op_a;
  operand_t op_b;

  modport master (
    output op_valid,
    output op_sel,
    output op_a,
    output op_b,
    input  op_ready
  );

  modport slave (
    input  op_valid,
    input  op_sel,
    input  op_a,
    input  op_b,
    output op_ready
  );

endinterface

// File: rtl/btn_debounce.sv
// Synchronizes and debounces one active-low push button.
//   clock  : system clock
//   reset  : synchronous, active-low
//   button : raw button level (asynchronous, idle 1)
//   stable : debounced level (1 = released)
//   press  : one-cycle pulse when stable falls 1 -> 0
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic stable,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync   <= '1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], button};
      press <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // Count would reach DEBOUNCE_CYCLES: accept the new level. The old
        // stable value being 1 means the new level is 0, i.e. a press.
        stable <= sync[1];
        cnt    <= '0;
        press  <= stable;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_btn_ctrl.sv
// Input-conditioning stage ahead of alu_board: synchronizes the switch
// operands, debounces the add/sub buttons and issues exactly one operation
// request per clean press over a valid/ready channel.
//   clock      : system clock
//   reset      : synchronous, active-low
//   ra1, ra2   : raw switch operands (asynchronous)
//   add_button : raw add button, active-low
//   sub_button : raw subtract button, active-low
//   op_bus     : request channel (op_valid/op_ready/op_sel/op_a/op_b)
module alu_btn_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [OPERAND_W-1:0] ra1,
  input  logic [OPERAND_W-1:0] ra2,
  input  logic                 add_button,
  input  logic                 sub_button,
  alu_btn_ctrl_if.master       op_bus
);

  operand_t a_meta, a_sync, b_meta, b_sync;
  operand_t a_q, b_q;
  logic     sel_q, sel_next;
  logic     load;
  logic     add_stable, add_press;
  logic     sub_stable, sub_press;
  state_t   state, state_next;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add_db (
    .clock  (clock),
    .reset  (reset),
    .button (add_button),
    .stable (add_stable),
    .press  (add_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sub_db (
    .clock  (clock),
    .reset  (reset),
    .button (sub_button),
    .stable (sub_stable),
    .press  (sub_press)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      a_meta <= '0;
      a_sync <= '0;
      b_meta <= '0;
      b_sync <= '0;
    end else begin
      a_meta <= ra1;
      a_sync <= a_meta;
      b_meta <= ra2;
      b_sync <= b_meta;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    sel_next   = sel_q;
    unique case (state)
      IDLE: begin
        // Simultaneous presses: add takes priority, sub is dropped.
        if (add_press || sub_press) begin
          load       = 1'b1;
          sel_next   = add_press ? OP_ADD : OP_SUB;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (op_bus.op_ready) state_next = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (add_stable && sub_stable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      sel_q <= OP_ADD;
    end else begin
      state <= state_next;
      sel_q <= sel_next;
      if (load) begin
        a_q <= a_sync;
        b_q <= b_sync;
      end
    end
  end

  assign op_bus.op_valid = (state == ISSUE);
  assign op_bus.op_sel   = sel_q;
  assign op_bus.op_a     = a_q;
  assign op_bus.op_b     = b_q;

endmodule

// File: tb/tb_alu_btn_ctrl.sv
module tb_alu_btn_ctrl;

  typedef struct {
    logic        sel;
    logic [3:0]  a;
    logic [3:0]  b;
    int unsigned rise;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [3:0] ra1, ra2;
  logic       add_button, sub_button;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];

  alu_btn_ctrl_if op_if ();

  alu_btn_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .ra1        (ra1),
    .ra2        (ra2),
    .add_button (add_button),
    .sub_button (sub_button),
    .op_bus     (op_if.master)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Inputs change 1 time unit after a falling edge, so the monitor (which
  // samples on the falling edge) always sees the values the previous rising
  // edge used.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  // The press is applied now; the first rising edge that samples it is
  // cyc+1, and op_valid is expected high from edge cyc+7 on.
  task automatic expect_req(input logic sel, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.sel  = sel;
    e.a    = a;
    e.b    = b;
    e.rise = cyc + 7;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if ({op_if.op_valid, op_if.op_sel, op_if.op_a, op_if.op_b} != 10'd0) begin
      n_fail++;
      $display("FAIL %s: valid=%0b sel=%0b a=%h b=%h, required all 0",
               name, op_if.op_valid, op_if.op_sel, op_if.op_a, op_if.op_b);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    logic prev_valid;
    logic have_cur;
    exp_t cur;
    prev_valid = 1'b0;
    have_cur   = 1'b0;
    forever begin
      @(negedge clock);
      if (op_if.op_valid === 1'b1) begin
        if (!prev_valid) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            have_cur = 1'b0;
            $display("FAIL unexpected_request: valid rose at cycle %0d, no request expected", cyc);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            if (cyc != cur.rise) begin
              n_fail++;
              $display("FAIL request_latency: valid rose at cycle %0d, required %0d", cyc, cur.rise);
            end
          end
        end else begin
          // op_ready was high on the edge just passed; valid must have dropped.
          n_checks++;
          if (op_if.op_ready === 1'b1) begin
            n_fail++;
            $display("FAIL valid_after_accept: valid=1 at cycle %0d, required 0", cyc);
          end
        end
        if (have_cur) begin
          n_checks++;
          if (op_if.op_sel !== cur.sel || op_if.op_a !== cur.a || op_if.op_b !== cur.b) begin
            n_fail++;
            $display("FAIL request_fields: cycle %0d sel=%0b a=%h b=%h, required sel=%0b a=%h b=%h",
                     cyc, op_if.op_sel, op_if.op_a, op_if.op_b, cur.sel, cur.a, cur.b);
          end
        end
      end
      prev_valid = (op_if.op_valid === 1'b1);
    end
  end

  initial begin
    reset          = 1'b0;
    op_if.op_ready = 1'b1;
    add_button     = 1'b1;
    sub_button     = 1'b1;
    ra1            = 4'h0;
    ra2            = 4'h0;
    step(3);
    check_zero("reset_state");
    reset = 1'b1;
    step(2);

    // 1. single add, held 20 cycles, ready always high
    ra1 = 4'h1; ra2 = 4'h1;
    step(3);
    expect_req(1'b0, 4'h1, 4'h1);
    add_button = 1'b0;
    step(20);
    add_button = 1'b1;
    step(12);

    // 2. bounce: toggling every 2 cycles never debounces
    for (int i = 0; i < 6; i++) begin
      add_button = 1'b0;
      step(2);
      add_button = 1'b1;
      step(2);
    end
    step(10);

    // 3. held request: ready low, switches change while pending
    ra1 = 4'h5; ra2 = 4'h3;
    op_if.op_ready = 1'b0;
    step(3);
    expect_req(1'b1, 4'h5, 4'h3);
    sub_button = 1'b0;
    step(7);
    ra1 = 4'hF; ra2 = 4'hF;
    step(5);
    op_if.op_ready = 1'b1;
    step(2);
    sub_button = 1'b1;
    step(12);

    // 4. simultaneous press: add wins
    ra1 = 4'h3; ra2 = 4'h2;
    step(3);
    expect_req(1'b0, 4'h3, 4'h2);
    add_button = 1'b0;
    sub_button = 1'b0;
    step(10);
    add_button = 1'b1;
    sub_button = 1'b1;
    step(12);

    // 5. reset mid-ISSUE, button held through reset
    ra1 = 4'h7; ra2 = 4'h6;
    op_if.op_ready = 1'b0;
    step(3);
    expect_req(1'b0, 4'h7, 4'h6);
    add_button = 1'b0;
    step(8);
    reset = 1'b0;
    step(1);
    check_zero("reset_mid_issue");
    reset = 1'b1;
    expect_req(1'b0, 4'h7, 4'h6);
    step(9);
    op_if.op_ready = 1'b1;
    step(1);
    add_button = 1'b1;
    step(12);

    // 6. sub press while add held in WAIT_RELEASE is ignored
    ra1 = 4'h2; ra2 = 4'h9;
    step(3);
    expect_req(1'b0, 4'h2, 4'h9);
    add_button = 1'b0;
    step(10);
    sub_button = 1'b0;
    step(10);
    add_button = 1'b1;
    sub_button = 1'b1;
    step(12);
    ra1 = 4'h8; ra2 = 4'h4;
    step(3);
    expect_req(1'b1, 4'h8, 4'h4);
    sub_button = 1'b0;
    step(10);
    sub_button = 1'b1;
    step(12);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_request: %0d expected requests never seen, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
